spi_req_arbiter: RTL and testbench



---
 rtl/spi_req_arbiter.sv | 125 ++++++++++++
 tb/tb_spi_req_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters; latches the winner's payload.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with a one-cycle err pulse.
module spi_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic                         spi_start,
  output logic [ADDR_BITS-1:0]         spi_address,
  output logic [DATA_BITS-1:0]         spi_data,
  input  logic                         spi_busy,
  input  logic                         spi_done,
  output logic                         err
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("spi_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          wait_err;
  int            idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) win = PW'(idx);
    end
  end

  assign found    = |req;
  assign ptr_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt;
  assign wait_err = (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) && !spi_done;
`else
  assign wait_err = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      spi_start   <= 1'b0;
      spi_address <= '0;
      spi_data    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      err         <= 1'b0;
`endif
    end else begin
`ifdef SPI_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found && !spi_busy) begin
            owner       <= win;
            grant       <= NUM_REQ'(1) << win;
            busy        <= 1'b1;
            spi_address <= req_addr[win*ADDR_BITS +: ADDR_BITS];
            spi_data    <= req_data[win*DATA_BITS +: DATA_BITS];
            spi_start   <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          spi_start <= 1'b0;
          state     <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
        end
        WAIT: begin
          // A timeout still acks the owner so its client never hangs.
          if (spi_done || wait_err) begin
            ack   <= grant;
            grant <= '0;
            ptr   <= ptr_next;
            state <= DONE;
`ifdef SPI_ARB_TIMEOUT_EN
            err   <= wait_err;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: stimulus queues expected transactions, a monitor checks them.
module tb_spi_req_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        spi_start;
  logic [7:0]  spi_address;
  logic [15:0] spi_data;
  logic        spi_busy;
  logic        spi_done;
  logic        err;

  spi_req_arbiter #(.NUM_REQ(4), .ADDR_BITS(8), .DATA_BITS(16), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .ack(ack), .busy(busy), .spi_start(spi_start), .spi_address(spi_address),
    .spi_data(spi_data), .spi_busy(spi_busy), .spi_done(spi_done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  oh;
    bit          to;
  } txn_t;

  txn_t start_q[$];
  txn_t ack_q[$];
  txn_t mt;
  int   checks = 0;
  int   errors = 0;
  bit   prev_done = 1'b0;
  bit   resp_en = 1'b1;
  int   resp_delay = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int slot, input logic [7:0] a, input logic [15:0] d, input bit to);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.oh   = 4'b0001 << slot;
    t.to   = to;
    start_q.push_back(t);
    ack_q.push_back(t);
  endtask

  task automatic set_slot(input int i, input logic [7:0] a, input logic [15:0] d);
    req_addr[i*8 +: 8]   = a;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin @(posedge clock); #1; n++; end while (!spi_start && n < 300);
    if (!spi_start) begin
      checks++; errors++;
      $display("FAIL %s: spi_start never seen got 0 want 1", name);
    end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin @(posedge clock); #1; n++; end while (ack == 4'b0 && n < 300);
    if (ack == 4'b0) begin
      checks++; errors++;
      $display("FAIL %s: ack never seen got 0 want nonzero", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: compares every start and ack against the queued expectations.
  always @(negedge clock) begin
    if (reset_n) begin
      if (spi_start) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got grant %0h want no start", grant);
        end else begin
          mt = start_q.pop_front();
          chk("start_addr", 32'(spi_address), 32'(mt.addr));
          chk("start_data", 32'(spi_data), 32'(mt.data));
          chk("start_grant", 32'(grant), 32'(mt.oh));
          chk("start_busy", 32'(busy), 32'd1);
        end
      end
      if (ack != 4'b0) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %0h want none", ack);
        end else begin
          mt = ack_q.pop_front();
          chk("ack_vec", 32'(ack), 32'(mt.oh));
          chk("ack_grant_clear", 32'(grant), 32'd0);
          chk("ack_busy", 32'(busy), 32'd1);
          chk("ack_err", 32'(err), 32'(mt.to));
          chk("ack_after_done", 32'(prev_done), 32'(!mt.to));
        end
      end else if (err) begin
        checks++; errors++;
        $display("FAIL err_without_ack: got err 1 want 0");
      end
    end
    prev_done = spi_done;
  end

  // SPI master model: pulses done resp_delay cycles after each start.
  initial begin
    spi_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (spi_start && resp_en) begin
        repeat (resp_delay) @(posedge clock);
        #1 spi_done = 1'b1;
        @(posedge clock);
        #1 spi_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    spi_busy = 1'b0;
    for (int i = 0; i < 4; i++) set_slot(i, 8'h10 + 8'(i), 16'hD000 + 16'(i));
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_addr", 32'(spi_address), 0);
    chk("rst_data", 32'(spi_data), 0);
    chk("rst_err", 32'(err), 0);
    #5 reset_n = 1'b1;
    idle(2);

    // All four requesting from ptr=0: order 0,1,2,3,0.
    resp_delay = 3;
    for (int i = 0; i < 5; i++) expect_txn(i % 4, 8'h10 + 8'(i % 4), 16'hD000 + 16'(i % 4), 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_start("rr_start");
    req = 4'b0000;
    wait_ack("rr_ack");
    idle(2);

    // Serve requester 1 alone (ptr -> 2), then 0 and 1 together: 0 first, then 1.
    expect_txn(1, 8'h11, 16'hD001, 1'b0);
    req = 4'b0010;
    wait_start("solo1_start");
    req = 4'b0000;
    wait_ack("solo1_ack");
    idle(2);
    expect_txn(0, 8'h10, 16'hD000, 1'b0);
    expect_txn(1, 8'h11, 16'hD001, 1'b0);
    req = 4'b0011;
    wait_start("wrap_start0");
    req = 4'b0010;
    wait_start("wrap_start1");
    req = 4'b0000;
    wait_ack("wrap_ack");
    idle(2);

    // Single requester 2 with a slow SPI master; check latency and busy fall.
    set_slot(2, 8'hA5, 16'h1234);
    resp_delay = 20;
    expect_txn(2, 8'hA5, 16'h1234, 1'b0);
    req = 4'b0100;
    @(posedge clock); #1;
    chk("lat_start", 32'(spi_start), 1);
    chk("lat_grant", 32'(grant), 32'b0100);
    req = 4'b0000;
    @(posedge clock); #1;
    chk("start_one_pulse", 32'(spi_start), 0);
    wait_ack("slow_ack");
    @(posedge clock); #1;
    chk("busy_fall", 32'(busy), 0);
    chk("ack_one_pulse", 32'(ack), 0);
    idle(1);

    // Requester 3 drops req and changes its payload mid-transaction.
    resp_delay = 5;
    expect_txn(3, 8'h13, 16'hD003, 1'b0);
    req = 4'b1000;
    wait_start("drop_start");
    req = 4'b0000;
    set_slot(3, 8'hEE, 16'hBEEF);
    @(posedge clock); #1;
    chk("payload_held_data", 32'(spi_data), 32'hD003);
    chk("payload_held_addr", 32'(spi_address), 32'h13);
    wait_ack("drop_ack");
    idle(2);

    // spi_busy holds off the grant until released.
    resp_delay = 3;
    spi_busy = 1'b1;
    expect_txn(0, 8'h10, 16'hD000, 1'b0);
    req = 4'b0001;
    idle(5);
    chk("busy_hold_start", 32'(spi_start), 0);
    chk("busy_hold_grant", 32'(grant), 0);
    spi_busy = 1'b0;
    @(posedge clock); #1;
    chk("busy_release_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    wait_ack("busy_ack");
    idle(2);

    // Reset in WAIT: everything clears asynchronously and no ack follows.
    resp_en = 1'b0;
    expect_txn(1, 8'h11, 16'hD001, 1'b0);
    req = 4'b0010;
    wait_start("rst_mid_start");
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(spi_address), 0);
    chk("midrst_data", 32'(spi_data), 0);
    void'(ack_q.pop_back());
    req = 4'b0000;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    chk("midrst_no_ack", 32'(ack), 0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: err and ack land together 16 cycles after WAIT entry.
    expect_txn(0, 8'h10, 16'hD000, 1'b1);
    req = 4'b0001;
    wait_start("to_start");
    req = 4'b0000;
    idle(16);
    chk("to_early_err", 32'(err), 0);
    @(posedge clock); #1;
    chk("to_err", 32'(err), 1);
    chk("to_ack", 32'(ack), 32'b0001);
    idle(2);
    resp_en = 1'b1;
    expect_txn(1, 8'h11, 16'hD001, 1'b0);
    req = 4'b0010;
`else
    resp_en = 1'b1;
    expect_txn(0, 8'h10, 16'hD000, 1'b0);
    req = 4'b0001;
`endif
    wait_start("post_start");
    req = 4'b0000;
    wait_ack("post_ack");
    idle(4);

    chk("start_q_drained", 32'(start_q.size()), 0);
    chk("ack_q_drained", 32'(ack_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
